des_56_loader: RTL and testbench
================================

DES_56_LOADER -- requirements
Module: des_56_loader

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 24, giving the maximum number of WAIT cycles before an error completion.
REQ-002 The block SHALL have the port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst  input  1  asynchronous reset, active low.
REQ-004 The block SHALL have the port in_data  input  8  byte-serial operand stream.
REQ-005 The block SHALL have the port in_valid  input  1  in_data is valid.
REQ-006 The block SHALL have the port in_ready  output  1  the block accepts a byte this cycle.
REQ-007 The block SHALL have the port core_start  output  1  start level to the downstream 56-bit cipher core.
REQ-008 The block SHALL have the port core_state  output  56  plaintext block to the core.
REQ-009 The block SHALL have the port core_key  output  56  key to the core.
REQ-010 The block SHALL have the port core_out  input  56  result from the core.
REQ-011 The block SHALL have the port core_out_valid  input  1  core result valid (level; may stay high).
REQ-012 The block SHALL have the port res_data  output  56  captured result.
REQ-013 The block SHALL have the port res_valid  output  1  result available.
REQ-014 The block SHALL have the port res_err  output  1  result is a timeout completion; qualified by res_valid.
REQ-015 The block SHALL have the port res_ready  input  1  consumer accepts the result.
REQ-016 The block SHALL have the port busy  output  1  high in every state except LOAD.

Function
REQ-017 The FSM SHALL have the states LOAD, START, WAIT and HOLD; it SHALL occupy LOAD after reset.
REQ-018 In LOAD, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 A byte SHALL be accepted only when in_valid and in_ready are both 1.
REQ-020 A 4-bit byte counter SHALL run 0..13; it SHALL advance by 1 per accepted byte and SHALL hold on cycles with no accepted byte.
REQ-021 Byte n (n = 0..6) SHALL be written to state_reg[55-8n -: 8]; byte n (n = 7..13) SHALL be written to key_reg[55-8(n-7) -: 8].
REQ-022 Acceptance of byte 13 SHALL move the FSM to START and SHALL clear the byte counter to 0.
REQ-023 core_start SHALL be 1 for exactly the one START cycle and 0 in every other cycle, guaranteeing a rising edge per operation; START SHALL always go to WAIT.
REQ-024 core_state SHALL equal state_reg and core_key SHALL equal key_reg at all times.
REQ-025 On WAIT entry, a 5-bit wait counter SHALL be cleared to 0; it SHALL increment once per WAIT cycle.
REQ-026 core_out_valid SHALL be ignored in the first WAIT cycle (wait counter = 0), to mask a stale level left from the previous operation.
REQ-027 In WAIT with wait counter >= 1 and core_out_valid = 1, the block SHALL load res_data <= core_out and res_err <= 0, and SHALL go to HOLD.
REQ-028 In WAIT with wait counter = TIMEOUT and core_out_valid = 0, the block SHALL load res_data <= 0 and res_err <= 1, and SHALL go to HOLD.
REQ-029 If valid and timeout coincide, the valid capture SHALL take priority.
REQ-030 On every exit from WAIT, key_reg and state_reg SHALL be cleared to 0, so that key material is not retained after use.
REQ-031 In HOLD, res_valid SHALL be 1, and res_data and res_err SHALL be stable.
REQ-032 In HOLD with res_ready = 1, res_valid SHALL go to 0, res_data SHALL be cleared to 0, and the FSM SHALL return to LOAD on the next cycle.
REQ-033 res_ready outside HOLD SHALL have no effect.
REQ-034 Latency SHALL be: last byte accepted on edge T gives core_start high during cycle T..T+1; res_valid SHALL rise on the edge after the first qualifying core_out_valid sample.

Reset
REQ-035 Assertion of rst (low) SHALL immediately, without waiting for clk, force: FSM = LOAD; byte counter = 0; wait counter = 0; state_reg = 0; key_reg = 0; res_data = 0; res_valid = 0; res_err = 0; core_start = 0; busy = 0.
REQ-036 Reset mid-load or mid-WAIT SHALL discard all partial operand and key bytes; the first byte after release SHALL be treated as byte 0.
REQ-037 in_ready SHALL be 0 while rst is low and SHALL be 1 from the first cycle after release.

Verification
REQ-038 The bench SHALL cover: bytes 0x01..0x0E with in_valid held high -> 14 accepted bytes, core_state = 0x01020304050607, core_key = 0x08090A0B0C0D0E, core_start high for exactly 1 cycle.
REQ-039 The bench SHALL cover: core_out_valid held high from the prior operation, new core_out = 0xABCDEF01234567 asserted on WAIT cycle 17 -> no capture on WAIT cycle 0; res_data = 0xABCDEF01234567; res_err = 0; key_reg = 0 in HOLD.
REQ-040 The bench SHALL cover: core_out_valid never asserted -> res_valid after TIMEOUT+1 WAIT cycles with res_err = 1 and res_data = 0.
REQ-041 The bench SHALL cover: res_ready low for 5 cycles in HOLD -> res_valid and res_data stable; in_ready = 0; then res_ready = 1 -> LOAD and in_ready = 1 next cycle.
REQ-042 The bench SHALL cover: in_valid toggled 1,0,1,0 -> only valid cycles are accepted and counted, and the byte order is preserved.
REQ-043 The bench SHALL cover: rst pulsed low after byte 9 and again during WAIT -> all outputs reach their reset values asynchronously; a fresh 14-byte load then completes correctly.

Source files
------------

// File: rtl/des_56_loader.sv
// Byte-serial operand loader and result holder for a 56-bit cipher core.
// Latency: core_start one cycle after byte 13; result registered on the edge after the first qualifying core_out_valid.
// Backpressure: in_ready only in LOAD; the result is held in HOLD until res_ready, with no new bytes accepted meanwhile.
module des_56_loader #(
    parameter int TIMEOUT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        core_start,
    output logic [55:0] core_state,
    output logic [55:0] core_key,
    input  logic [55:0] core_out,
    input  logic        core_out_valid,
    output logic [55:0] res_data,
    output logic        res_valid,
    output logic        res_err,
    input  logic        res_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    localparam logic [4:0] TIMEOUT_W = 5'(TIMEOUT);

    state_e      state_q,      state_d;
    logic [3:0]  byte_cnt_q,   byte_cnt_d;
    logic [4:0]  wait_cnt_q,   wait_cnt_d;
    logic [55:0] state_reg_q,  state_reg_d;
    logic [55:0] key_reg_q,    key_reg_d;
    logic [55:0] res_data_q,   res_data_d;
    logic        res_valid_q,  res_valid_d;
    logic        res_err_q,    res_err_d;
    logic        core_start_q, core_start_d;
    logic        busy_q,       busy_d;

    logic        byte_acc;
    logic [2:0]  slot;
    logic [5:0]  lsb;

    // in_ready is gated by rst directly so it drops the moment reset is applied
    assign in_ready = rst && (state_q == S_LOAD);
    assign byte_acc = in_valid && in_ready;

    // Bytes 0..6 and 7..13 each fill their register from the MSB byte downward
    assign slot = (byte_cnt_q < 4'd7) ? byte_cnt_q[2:0] : 3'(byte_cnt_q - 4'd7);
    assign lsb  = 6'd48 - {slot, 3'b000};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        state_reg_d = state_reg_q;
        key_reg_d   = key_reg_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;

        case (state_q)
            S_LOAD: begin
                if (byte_acc) begin
                    if (byte_cnt_q < 4'd7) begin
                        state_reg_d[lsb +: 8] = in_data;
                    end else begin
                        key_reg_d[lsb +: 8] = in_data;
                    end
                    if (byte_cnt_q == 4'd13) begin
                        byte_cnt_d = 4'd0;
                        state_d    = S_START;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end

            S_START: begin
                wait_cnt_d = 5'd0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                // The first WAIT cycle ignores a valid level left over from the previous operation
                if ((wait_cnt_q != 5'd0) && core_out_valid) begin
                    res_data_d  = core_out;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (wait_cnt_q == TIMEOUT_W) begin
                    res_data_d  = 56'd0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end

                if (state_d != S_WAIT) begin
                    state_reg_d = 56'd0;
                    key_reg_d   = 56'd0;
                    wait_cnt_d  = 5'd0;
                end
            end

            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_data_d  = 56'd0;
                    state_d     = S_LOAD;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase

        core_start_d = (state_d == S_START);
        busy_d       = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LOAD;
            byte_cnt_q   <= 4'd0;
            wait_cnt_q   <= 5'd0;
            state_reg_q  <= 56'd0;
            key_reg_q    <= 56'd0;
            res_data_q   <= 56'd0;
            res_valid_q  <= 1'b0;
            res_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            state_reg_q  <= state_reg_d;
            key_reg_q    <= key_reg_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            res_err_q    <= res_err_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
        end
    end

    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign core_state = state_reg_q;
    assign core_key   = key_reg_q;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_des_56_loader.sv
// Randomized self-checking bench for des_56_loader against a transaction-level reference model.
module tb_des_56_loader;

    localparam int TIMEOUT = 24;
    localparam int NEVER   = 1000;

    typedef logic [7:0] bytes_t [14];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        core_start;
    logic [55:0] core_state;
    logic [55:0] core_key;
    logic [55:0] core_out = 56'd0;
    logic        core_out_valid = 1'b0;
    logic [55:0] res_data;
    logic        res_valid;
    logic        res_err;
    logic        res_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int start_hi = 0;
    int acc_cnt  = 0;

    des_56_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .core_start     (core_start),
        .core_state     (core_state),
        .core_key       (core_key),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .res_err        (res_err),
        .res_ready      (res_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (core_start === 1'b1) start_hi++;
    always @(posedge clk) if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Big-endian packing of seven bytes starting at base; bytes at or beyond n read as zero
    function automatic logic [55:0] pack7(input bytes_t b, input int base, input int n);
        logic [55:0] v = '0;
        for (int i = 0; i < 7; i++) begin
            v = (v << 8) | ((base + i < n) ? 56'(b[base + i]) : 56'd0);
        end
        return v;
    endfunction

    task automatic rand_bytes(output bytes_t b);
        for (int i = 0; i < 14; i++) b[i] = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"},   in_ready,   1'b0);
        check_eq({tag, "_busy"},       busy,       1'b0);
        check_eq({tag, "_core_start"}, core_start, 1'b0);
        check_eq({tag, "_core_state"}, core_state, 56'd0);
        check_eq({tag, "_core_key"},   core_key,   56'd0);
        check_eq({tag, "_res_valid"},  res_valid,  1'b0);
        check_eq({tag, "_res_err"},    res_err,    1'b0);
        check_eq({tag, "_res_data"},   res_data,   56'd0);
    endtask

    // Entered and left on a negedge; drives n bytes, optionally with idle gaps carrying junk data
    task automatic load(input bytes_t b, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(1, 2);
                repeat (g) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_op(input bytes_t b, input bit gaps, input int valid_at, input bit stale,
                          input int hold_cycles, input logic [55:0] new_out);
        int          acc0;
        int          s0;
        int          seen;
        int          exp_w;
        bit          exp_err;
        logic [55:0] exp_data;

        exp_err  = !(valid_at >= 1 && valid_at <= TIMEOUT);
        exp_w    = exp_err ? TIMEOUT : valid_at;
        exp_data = exp_err ? 56'd0 : new_out;

        acc0 = acc_cnt;
        s0   = start_hi;
        res_ready = 1'($urandom_range(0, 1));
        load(b, gaps, 14);
        res_ready = 1'b0;

        check_eq("start_lvl",   core_start, 1'b1);
        check_eq("start_state", core_state, pack7(b, 0, 14));
        check_eq("start_key",   core_key,   pack7(b, 7, 14));
        check_eq("start_busy",  busy,       1'b1);
        check_eq("start_rdy",   in_ready,   1'b0);
        check_eq("accepted",    acc_cnt - acc0, 14);

        core_out_valid = stale;
        core_out       = 56'h11_2233_4455_6677;
        seen = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                seen = k;
                break;
            end
            if (k == 0) check_eq("wait0_start", core_start, 1'b0);
            core_out_valid = (stale && k == 0) || (k >= valid_at);
            if (k >= valid_at) core_out = new_out;
        end

        check_eq("rv_cycle",   seen,       exp_w + 1);
        check_eq("hold_data",  res_data,   exp_data);
        check_eq("hold_err",   res_err,    exp_err);
        check_eq("hold_key",   core_key,   56'd0);
        check_eq("hold_state", core_state, 56'd0);
        check_eq("start_cnt",  start_hi - s0, 1);

        for (int h = 0; h < hold_cycles; h++) begin
            core_out = {24'($urandom), 32'($urandom)};
            @(negedge clk);
            check_eq("stall_rv",   res_valid, 1'b1);
            check_eq("stall_data", res_data,  exp_data);
            check_eq("stall_rdy",  in_ready,  1'b0);
        end

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("rel_rv",   res_valid, 1'b0);
        check_eq("rel_data", res_data,  56'd0);
        check_eq("rel_rdy",  in_ready,  1'b1);
        check_eq("rel_busy", busy,      1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t b;
        bytes_t bz;

        #3;
        check_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por_clk");
        #2 rst = 1'b1;
        #1 check_eq("rel_in_ready", in_ready, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 14; i++) b[i] = 8'(i + 1);
        run_op(b, 1'b0, 5, 1'b0, 0, 56'h0F_1E2D_3C4B_5A69);

        rand_bytes(b);
        run_op(b, 1'b0, 17, 1'b1, 5, 56'hAB_CDEF_0123_4567);

        rand_bytes(b);
        run_op(b, 1'b0, NEVER, 1'b0, 1, 56'h55_5555_5555_5555);

        rand_bytes(b);
        run_op(b, 1'b1, TIMEOUT, 1'b0, 2, 56'h12_3456_789A_BCDE);

        rand_bytes(b);
        load(b, 1'b1, 10);
        check_eq("part_state", core_state, pack7(b, 0, 10));
        check_eq("part_key",   core_key,   pack7(b, 7, 10));
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_load");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rand_bytes(b);
        run_op(b, 1'b0, 3, 1'b1, 0, 56'h00_0000_0000_0001);

        rand_bytes(bz);
        load(bz, 1'b0, 14);
        core_out_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midwait_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_wait");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rand_bytes(b);
        run_op(b, 1'b1, 2, 1'b0, 1, 56'hFE_DCBA_9876_5432);

        for (int t = 0; t < 6; t++) begin
            rand_bytes(b);
            run_op(b, 1'($urandom_range(0, 1)), $urandom_range(1, 30), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), {24'($urandom), 32'($urandom)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
